// File: rtl/exec_wb_pkg.sv
// Shared types and sizing for the execute-to-writeback arbiter.
// wb_entry_t is the payload carried from each execute pipe to a writeback port.
package exec_wb_pkg;

    localparam int NUM_SRC   = 4;
    localparam int NUM_WB    = 3;
    localparam int DATA_W    = 32;
    localparam int PRD_W     = 7;
    localparam int ROB_W     = 6;
    localparam int BUF_DEPTH = 2;

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam int SRC_ALU1 = 0;
    localparam int SRC_ALU2 = 1;
    localparam int SRC_MUL  = 2;
    localparam int SRC_MEM  = 3;

    typedef struct packed {
        logic [PRD_W-1:0]  prd;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_idx;
        logic              has_dest;
        logic              br_mispred;
    } wb_entry_t;

    function automatic logic [SRC_W-1:0] src_wrap_inc(input logic [SRC_W-1:0] s);
        return (s == SRC_W'(NUM_SRC - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result buffer: small circular FIFO with synchronous reset and flush.
// Payload storage is not reset; only pointers and count are cleared.
module wb_src_fifo
    import exec_wb_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output wb_entry_t                    head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    wb_entry_t        mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/exec_wb_arbiter.sv
// Schedules execute-pipe results onto the shared writeback ports, round-robin across sources.
// Define EXWB_BYPASS_EN to let an empty source's live input compete in the same cycle.
module exec_wb_arbiter
    import exec_wb_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic      [NUM_SRC-1:0]          src_valid,
    output logic      [NUM_SRC-1:0]          src_ready,
    input  wb_entry_t [NUM_SRC-1:0]          src_entry,
    output logic      [NUM_WB-1:0]           wb_valid,
    output wb_entry_t [NUM_WB-1:0]           wb_entry,
    output logic      [NUM_WB-1:0][SRC_W-1:0] wb_src_id
);

    logic      [NUM_SRC-1:0]            fifo_full;
    logic      [NUM_SRC-1:0]            fifo_empty;
    logic      [NUM_SRC-1:0][CNT_W-1:0] fifo_count;
    wb_entry_t [NUM_SRC-1:0]            fifo_head;
    logic      [NUM_SRC-1:0]            push;
    logic      [NUM_SRC-1:0]            pop;
    logic      [NUM_SRC-1:0]            byp;
    logic      [NUM_SRC-1:0]            cand;
    wb_entry_t [NUM_SRC-1:0]            cand_entry;

    logic      [SRC_W-1:0]              rr_ptr;
    logic      [SRC_W-1:0]              last_src;
    logic                               any_gnt;
    logic      [NUM_SRC-1:0]            gnt_mask;
    logic      [NUM_WB-1:0]             gnt_vld;
    logic      [NUM_WB-1:0][SRC_W-1:0]  gnt_src;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // Ready comes from the registered count only, never from a same-cycle pop.
        assign src_ready[g] = ~rst & (fifo_count[g] < CNT_W'(BUF_DEPTH));
        assign push[g]      = src_valid[g] & ~fifo_full[g] & ~byp[g];
        assign pop[g]       = gnt_mask[g] & ~fifo_empty[g];

`ifdef EXWB_BYPASS_EN
        assign cand[g]       = ~fifo_empty[g] | (src_valid[g] & src_ready[g]);
        assign cand_entry[g] = fifo_empty[g] ? src_entry[g] : fifo_head[g];
        assign byp[g]        = gnt_mask[g] & fifo_empty[g];
`else
        assign cand[g]       = ~fifo_empty[g];
        assign cand_entry[g] = fifo_head[g];
        assign byp[g]        = 1'b0;
`endif

        wb_src_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[g]),
            .pop   (pop[g]),
            .entry (src_entry[g]),
            .count (fifo_count[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .head  (fifo_head[g])
        );
    end

    // Rotating scan: the k-th candidate found from rr_ptr takes port k.
    always_comb begin
        int               n;
        logic [SRC_W-1:0] idx;
        n        = 0;
        idx      = '0;
        gnt_vld  = '0;
        gnt_src  = '0;
        gnt_mask = '0;
        last_src = rr_ptr;
        any_gnt  = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            idx = SRC_W'((int'(rr_ptr) + j) % NUM_SRC);
            if (cand[idx] && n < NUM_WB) begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (k == n) begin
                        gnt_vld[k] = 1'b1;
                        gnt_src[k] = idx;
                    end
                end
                gnt_mask[idx] = 1'b1;
                last_src      = idx;
                any_gnt       = 1'b1;
                n++;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= '0;
            wb_entry  <= '0;
            wb_src_id <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            wb_valid <= '0;
            rr_ptr   <= '0;
        end else begin
            wb_valid <= gnt_vld;
            for (int k = 0; k < NUM_WB; k++) begin
                if (gnt_vld[k]) begin
                    wb_entry[k]  <= cand_entry[gnt_src[k]];
                    wb_src_id[k] <= gnt_src[k];
                end
            end
            if (any_gnt) rr_ptr <= src_wrap_inc(last_src);
        end
    end

endmodule

// File: tb/tb_exec_wb_arbiter.sv
// Directed bench for exec_wb_arbiter: a per-cycle vector table plus hand sequences for reset.
// Expectations switch with EXWB_BYPASS_EN.
module tb_exec_wb_arbiter;
    import exec_wb_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic      [NUM_SRC-1:0]       src_valid;
    logic      [NUM_SRC-1:0]       src_ready;
    wb_entry_t [NUM_SRC-1:0]       src_entry;
    logic      [NUM_WB-1:0]        wb_valid;
    wb_entry_t [NUM_WB-1:0]        wb_entry;
    logic      [NUM_WB-1:0][SRC_W-1:0] wb_src_id;

    exec_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_entry (src_entry),
        .wb_valid  (wb_valid),
        .wb_entry  (wb_entry),
        .wb_src_id (wb_src_id)
    );

    always #5 clk = ~clk;

`ifdef EXWB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    int n_chk = 0;
    int n_err = 0;

    // One row: outputs expected just after an edge, then inputs driven for the next edge.
    typedef struct {
        logic             fl;
        logic [3:0]       v;
        logic [3:0][31:0] d;
        logic [3:0]       rdy;
        logic [2:0]       wv;
        logic [2:0][1:0]  sid;
        logic [2:0][31:0] wd;
        logic             rrc;
        logic [1:0]       rr;
    } vec_t;

    vec_t tbl[$];

    function automatic wb_entry_t ent(input logic [31:0] d);
        wb_entry_t e;
        e.prd        = d[6:0];
        e.data       = d;
        e.rob_idx    = d[13:8];
        e.has_dest   = d[0];
        e.br_mispred = d[1];
        return e;
    endfunction

    function automatic void add(input logic fl, input logic [3:0] v,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] rdy, input logic [2:0] wv,
                                input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input logic rrc, input logic [1:0] rr);
        vec_t r;
        r.fl  = fl;   r.v  = v;  r.d  = {d3, d2, d1, d0};
        r.rdy = rdy;  r.wv = wv; r.sid = {s2, s1, s0}; r.wd = {w2, w1, w0};
        r.rrc = rrc;  r.rr = rr;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        wb_entry_t single;

        // fl v  d0..d3 | rdy wv sid0..2 | wd0..2 | rr check
`ifdef EXWB_BYPASS_EN
        add(1, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 1);
        add(0, 4'hF, 'hA0, 'hA1, 'hA2, 'hA3,        4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h7, 0, 1, 2, 'hA0, 'hA1, 'hA2, 1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h1, 3, 0, 0, 'hA3, 0, 0,       1, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 0);
`else
        // flush to realign rr, then four-way contention
        add(1, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 1);
        add(0, 4'hF, 'hA0, 'hA1, 'hA2, 'hA3,        4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h7, 0, 1, 2, 'hA0, 'hA1, 'hA2, 1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h1, 3, 0, 0, 'hA3, 0, 0,       1, 0);
        // build 5 buffered entries, then flush with new inputs on srcs 0,1
        add(0, 4'hF, 'hB0, 'hB1, 'hB2, 'hB3,        4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 0);
        add(0, 4'hF, 'hB4, 'hB5, 'hB6, 'hB7,        4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        add(1, 4'h3, 'hC0, 'hC1, 0, 0,              4'h7, 3'h7, 0, 1, 2, 'hB0, 'hB1, 'hB2, 1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        // MUL backpressure: skipped once by the rotation, fills, then drains in order
        add(0, 4'hF, 'hD0, 'hD1, 'hE0, 'hD3,        4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        add(0, 4'h7, 'hD4, 'hD5, 'hE1, 0,           4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          0, 0);
        add(0, 4'h4, 0, 0, 'hE2, 0,                 4'hF, 3'h7, 0, 1, 2, 'hD0, 'hD1, 'hE0, 1, 3);
        add(0, 4'h4, 0, 0, 'hE3, 0,                 4'hB, 3'h7, 3, 0, 1, 'hD3, 'hD4, 'hD5, 1, 2);
        add(0, 4'h4, 0, 0, 'hE3, 0,                 4'hF, 3'h1, 2, 0, 0, 'hE1, 0, 0,       1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h1, 2, 0, 0, 'hE2, 0, 0,       1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h1, 2, 0, 0, 'hE3, 0, 0,       1, 3);
        add(0, 4'h0, 0, 0, 0, 0,                    4'hF, 3'h0, 0, 0, 0, 0, 0, 0,          1, 3);
`endif

        // Reset held two cycles with every source asserting valid
        rst       = 1'b1;
        flush     = 1'b0;
        src_valid = 4'hF;
        src_entry = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk($sformatf("reset%0d src_ready", c), 64'(src_ready), 64'h0);
            chk($sformatf("reset%0d wb_valid", c), 64'(wb_valid), 64'h0);
            chk($sformatf("reset%0d wb_entry0", c), {17'b0, wb_entry[0]}, 64'h0);
        end
        rst       = 1'b0;
        src_valid = 4'h0;
        #1;
        chk("post-reset src_ready", 64'(src_ready), 64'hF);
        chk("post-reset rr_ptr", 64'(dut.rr_ptr), 64'h0);

        // Single ALU1 result
        single.prd        = 7'd5;
        single.data       = 32'hDEAD_BEEF;
        single.rob_idx    = 6'd3;
        single.has_dest   = 1'b1;
        single.br_mispred = 1'b0;
        src_valid              = 4'b0001;
        src_entry[SRC_ALU1]    = single;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            if (e == 1) src_valid = 4'h0;
            chk($sformatf("single e%0d wb_valid", e), 64'(wb_valid),
                (e == LAT) ? 64'h1 : 64'h0);
            if (e == LAT) begin
                chk("single wb_entry0", {17'b0, wb_entry[0]}, {17'b0, single});
                chk("single wb_src_id0", 64'(wb_src_id[0]), 64'(SRC_ALU1));
            end
        end

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            chk($sformatf("row%0d src_ready", i), 64'(src_ready), 64'(tbl[i].rdy));
            chk($sformatf("row%0d wb_valid", i), 64'(wb_valid), 64'(tbl[i].wv));
            for (int k = 0; k < NUM_WB; k++) begin
                if (tbl[i].wv[k]) begin
                    chk($sformatf("row%0d wb_entry%0d", i, k), {17'b0, wb_entry[k]},
                        {17'b0, ent(tbl[i].wd[k])});
                    chk($sformatf("row%0d wb_src_id%0d", i, k), 64'(wb_src_id[k]),
                        64'(tbl[i].sid[k]));
                end
            end
            if (tbl[i].rrc)
                chk($sformatf("row%0d rr_ptr", i), 64'(dut.rr_ptr), 64'(tbl[i].rr));
            flush     = tbl[i].fl;
            src_valid = tbl[i].v;
            for (int s = 0; s < NUM_SRC; s++) src_entry[s] = ent(tbl[i].d[s]);
        end

        // Reset in the middle of traffic clears buffers and payload registers
        src_valid = 4'hF;
        for (int s = 0; s < NUM_SRC; s++) src_entry[s] = ent(32'hF0 + 32'(s));
        @(posedge clk); #1;
        src_valid = 4'h0;
        rst       = 1'b1;
        @(posedge clk); #1;
        chk("midrst wb_valid", 64'(wb_valid), 64'h0);
        chk("midrst src_ready", 64'(src_ready), 64'h0);
        chk("midrst rr_ptr", 64'(dut.rr_ptr), 64'h0);
        for (int k = 0; k < NUM_WB; k++) begin
            chk($sformatf("midrst wb_entry%0d", k), {17'b0, wb_entry[k]}, 64'h0);
            chk($sformatf("midrst wb_src_id%0d", k), 64'(wb_src_id[k]), 64'h0);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst idle%0d wb_valid", c), 64'(wb_valid), 64'h0);
            chk($sformatf("midrst idle%0d src_ready", c), 64'(src_ready), 64'hF);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
